// File: rtl/fetch_ibus_ctrl_pkg.sv
// Shared types for the fetch-stage instruction-bus controller.
// Defines the ibus request/response structs and the fetch FSM states.
package fetch_ibus_ctrl_pkg;

   typedef struct packed {
      logic        valid;
      logic [31:0] addr;
   } ibus_req_t;

   typedef struct packed {
      logic        addr_ok;
      logic        data_ok;
      logic [31:0] data;
   } ibus_resp_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      WAIT = 2'd2,
      HOLD = 2'd3
   } fetch_state_t;

   localparam logic [31:0] DEFAULT_NOP = 32'h0000_0000;

endpackage

// File: rtl/fetch_ibus_ctrl_if.sv
// Instruction-bus bundle between the fetch controller (master) and memory (slave).
interface fetch_ibus_ctrl_if;
   import fetch_ibus_ctrl_pkg::*;

   ibus_req_t  ireq;
   ibus_resp_t iresp;

   modport master (output ireq, input iresp);
   modport slave  (input ireq, output iresp);

endinterface

// File: rtl/fetch_ibus_ctrl.sv
// Fetch-stage ibus controller: one outstanding read, hands {pc, instr, adel} to decode,
// stalls the PC register until its slot is delivered, and discards fetches orphaned by flush.
module fetch_ibus_ctrl
   import fetch_ibus_ctrl_pkg::*;
#(
   parameter logic [31:0] NOP_INSTR   = DEFAULT_NOP,
   parameter bit          CHECK_ALIGN = 1'b1
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [31:0]        f_pc,
   input  logic               f_vreq,
   input  logic               flush,
   input  logic               d_stall,
   fetch_ibus_ctrl_if.master  bus,
   output logic               f_stall,
   output logic               d_valid,
   output logic [31:0]        d_pc,
   output logic [31:0]        d_instr,
   output logic               d_adel
);

   fetch_state_t state, state_next;
   logic         kill, kill_next;
   logic [31:0]  req_addr;
   logic [31:0]  hold_instr;
   logic         req_load, hold_load;
   logic         deliver, adel_deliver;
   logic [31:0]  deliver_data;
   logic         aligned;

   assign aligned = !CHECK_ALIGN || (f_pc[1:0] == 2'b00);

   always_comb begin
      state_next   = state;
      kill_next    = kill;
      req_load     = 1'b0;
      hold_load    = 1'b0;
      deliver      = 1'b0;
      adel_deliver = 1'b0;
      bus.ireq     = '0;
      deliver_data = (state == HOLD) ? hold_instr : bus.iresp.data;
      unique case (state)
         IDLE: begin
            bus.ireq.addr = f_pc;
            if (f_vreq && !flush && !kill) begin
               if (aligned) begin
                  bus.ireq.valid = 1'b1;
                  req_load       = 1'b1;
                  state_next     = bus.iresp.addr_ok ? WAIT : REQ;
               end else if (!d_stall) begin
                  adel_deliver = 1'b1;
               end
            end
         end
         // A posted request is never retracted; a flush only marks its data as orphaned.
         REQ: begin
            bus.ireq.valid = 1'b1;
            bus.ireq.addr  = req_addr;
            if (flush) kill_next = 1'b1;
            if (bus.iresp.addr_ok) state_next = WAIT;
         end
         WAIT: begin
            if (bus.iresp.data_ok) begin
               if (kill || flush) begin
                  kill_next  = 1'b0;
                  state_next = IDLE;
               end else if (!d_stall) begin
                  deliver    = 1'b1;
                  state_next = IDLE;
               end else begin
                  hold_load  = 1'b1;
                  state_next = HOLD;
               end
            end else if (flush) begin
               kill_next = 1'b1;
            end
         end
         HOLD: begin
            if (flush) begin
               state_next = IDLE;
            end else if (!d_stall) begin
               deliver    = 1'b1;
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   assign f_stall = f_vreq && !flush && !deliver && !adel_deliver;

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         kill       <= 1'b0;
         req_addr   <= '0;
         hold_instr <= '0;
      end else begin
         state <= state_next;
         kill  <= kill_next;
         if (req_load)  req_addr   <= f_pc;
         if (hold_load) hold_instr <= bus.iresp.data;
      end
   end

   // Flush beats d_stall so a squashed slot never lingers in decode.
   always_ff @(posedge clk) begin
      if (reset) begin
         d_valid <= 1'b0;
         d_pc    <= '0;
         d_instr <= NOP_INSTR;
         d_adel  <= 1'b0;
      end else if (flush) begin
         d_valid <= 1'b0;
         d_instr <= NOP_INSTR;
      end else if (!d_stall) begin
         d_valid <= deliver || adel_deliver;
         if (deliver) begin
            d_pc    <= req_addr;
            d_instr <= deliver_data;
            d_adel  <= 1'b0;
         end else if (adel_deliver) begin
            d_pc    <= f_pc;
            d_instr <= NOP_INSTR;
            d_adel  <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_fetch_ibus_ctrl.sv
// Directed testbench for fetch_ibus_ctrl: hand-sequenced ibus slave, hand-computed expectations.
module tb_fetch_ibus_ctrl;
   import fetch_ibus_ctrl_pkg::*;

   logic        clk;
   logic        reset;
   logic [31:0] f_pc;
   logic        f_vreq;
   logic        flush;
   logic        d_stall;
   logic        f_stall;
   logic        d_valid;
   logic [31:0] d_pc;
   logic [31:0] d_instr;
   logic        d_adel;

   int testsRun;
   int testsFailed;

   fetch_ibus_ctrl_if bus ();

   fetch_ibus_ctrl #(.NOP_INSTR(32'h0000_0000), .CHECK_ALIGN(1'b1)) dut (
      .clk     (clk),
      .reset   (reset),
      .f_pc    (f_pc),
      .f_vreq  (f_vreq),
      .flush   (flush),
      .d_stall (d_stall),
      .bus     (bus.master),
      .f_stall (f_stall),
      .d_valid (d_valid),
      .d_pc    (d_pc),
      .d_instr (d_instr),
      .d_adel  (d_adel)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      testsRun++;
      if (got !== exp) begin
         testsFailed++;
         $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Inputs change 1ns after the edge; combinational outputs are checked 1ns later.
   task automatic applyStimulus(input logic vreq, input logic [31:0] pc, input logic fl,
                                input logic ds, input logic aok, input logic dok,
                                input logic [31:0] data);
      f_vreq              = vreq;
      f_pc                = pc;
      flush               = fl;
      d_stall             = ds;
      bus.iresp.addr_ok   = aok;
      bus.iresp.data_ok   = dok;
      bus.iresp.data      = data;
      #1;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      testsRun    = 0;
      testsFailed = 0;
      reset       = 1'b1;
      applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
      tick();
      tick();

      // 1: reset state and a single-cycle hit
      checkOutput("rst_d_valid", {31'b0, d_valid}, 32'd0);
      checkOutput("rst_d_pc", d_pc, 32'h0);
      checkOutput("rst_d_instr", d_instr, 32'h0);
      checkOutput("rst_d_adel", {31'b0, d_adel}, 32'd0);
      checkOutput("rst_ireq_valid", {31'b0, bus.ireq.valid}, 32'd0);
      reset = 1'b0;
      applyStimulus(1'b1, 32'hbfc0_0000, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
      checkOutput("t1_ireq_valid", {31'b0, bus.ireq.valid}, 32'd1);
      checkOutput("t1_ireq_addr", bus.ireq.addr, 32'hbfc0_0000);
      checkOutput("t1_fstall_issue", {31'b0, f_stall}, 32'd1);
      tick();
      applyStimulus(1'b1, 32'hbfc0_0000, 1'b0, 1'b0, 1'b0, 1'b1, 32'h2408_0001);
      checkOutput("t1_fstall_dataok", {31'b0, f_stall}, 32'd0);
      checkOutput("t1_dvalid_early", {31'b0, d_valid}, 32'd0);
      tick();
      checkOutput("t1_d_valid", {31'b0, d_valid}, 32'd1);
      checkOutput("t1_d_pc", d_pc, 32'hbfc0_0000);
      checkOutput("t1_d_instr", d_instr, 32'h2408_0001);
      checkOutput("t1_d_adel", {31'b0, d_adel}, 32'd0);

      // 2: addr_ok withheld for three cycles; request must stay put
      applyStimulus(1'b1, 32'hbfc0_0004, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
      checkOutput("t2_idle_valid", {31'b0, bus.ireq.valid}, 32'd1);
      checkOutput("t2_idle_addr", bus.ireq.addr, 32'hbfc0_0004);
      checkOutput("t2_idle_fstall", {31'b0, f_stall}, 32'd1);
      tick();
      checkOutput("t2_d_valid_drop", {31'b0, d_valid}, 32'd0);
      for (int i = 0; i < 3; i++) begin
         applyStimulus(1'b1, 32'hbfc0_0004, (i == 0), 1'b0, (i == 2), 1'b0, 32'h0);
         checkOutput($sformatf("t2_req_valid%0d", i), {31'b0, bus.ireq.valid}, 32'd1);
         checkOutput($sformatf("t2_req_addr%0d", i), bus.ireq.addr, 32'hbfc0_0004);
         checkOutput($sformatf("t2_req_fstall%0d", i), {31'b0, f_stall}, (i == 0) ? 32'd0 : 32'd1);
         tick();
      end
      // Flush in REQ (cycle 0) orphaned this fetch; its data must be discarded.
      checkOutput("t2_kill_set", {31'b0, dut.kill}, 32'd1);
      applyStimulus(1'b1, 32'hbfc0_0004, 1'b0, 1'b0, 1'b0, 1'b1, 32'h5555_5555);
      checkOutput("t2_orphan_fstall", {31'b0, f_stall}, 32'd1);
      tick();
      checkOutput("t2_orphan_dvalid", {31'b0, d_valid}, 32'd0);
      checkOutput("t2_kill_clr", {31'b0, dut.kill}, 32'd0);
      applyStimulus(1'b1, 32'hbfc0_0004, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
      checkOutput("t2_reissue_addr", bus.ireq.addr, 32'hbfc0_0004);
      tick();

      // 3: decode stalls when data arrives -> HOLD, then released
      applyStimulus(1'b1, 32'hbfc0_0004, 1'b0, 1'b1, 1'b0, 1'b1, 32'haabb_ccdd);
      checkOutput("t3_fstall_wait", {31'b0, f_stall}, 32'd1);
      tick();
      checkOutput("t3_state_hold", 32'(dut.state), 32'(HOLD));
      checkOutput("t3_d_instr_held", d_instr, 32'h0);
      checkOutput("t3_d_valid_held", {31'b0, d_valid}, 32'd0);
      applyStimulus(1'b1, 32'hbfc0_0004, 1'b0, 1'b1, 1'b0, 1'b1, 32'h1111_1111);
      checkOutput("t3_fstall_hold", {31'b0, f_stall}, 32'd1);
      checkOutput("t3_hold_ireq", {31'b0, bus.ireq.valid}, 32'd0);
      tick();
      applyStimulus(1'b1, 32'hbfc0_0004, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
      checkOutput("t3_fstall_release", {31'b0, f_stall}, 32'd0);
      tick();
      checkOutput("t3_d_valid", {31'b0, d_valid}, 32'd1);
      checkOutput("t3_d_instr", d_instr, 32'haabb_ccdd);
      checkOutput("t3_d_pc", d_pc, 32'hbfc0_0004);

      // 4: flush while waiting for data; orphan must be dropped before the redirect fetch
      applyStimulus(1'b1, 32'hbfc0_0008, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
      tick();
      applyStimulus(1'b1, 32'hbfc0_0100, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
      checkOutput("t4_flush_fstall", {31'b0, f_stall}, 32'd0);
      tick();
      checkOutput("t4_flush_dinstr", d_instr, 32'h0);
      checkOutput("t4_flush_dvalid", {31'b0, d_valid}, 32'd0);
      applyStimulus(1'b1, 32'hbfc0_0100, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
      checkOutput("t4_noissue_wait", {31'b0, bus.ireq.valid}, 32'd0);
      tick();
      applyStimulus(1'b1, 32'hbfc0_0100, 1'b0, 1'b0, 1'b0, 1'b1, 32'hdead_beef);
      checkOutput("t4_noissue_orphan", {31'b0, bus.ireq.valid}, 32'd0);
      checkOutput("t4_orphan_fstall", {31'b0, f_stall}, 32'd1);
      tick();
      checkOutput("t4_orphan_dvalid", {31'b0, d_valid}, 32'd0);
      applyStimulus(1'b1, 32'hbfc0_0100, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
      checkOutput("t4_new_valid", {31'b0, bus.ireq.valid}, 32'd1);
      checkOutput("t4_new_addr", bus.ireq.addr, 32'hbfc0_0100);
      tick();
      applyStimulus(1'b1, 32'hbfc0_0100, 1'b0, 1'b0, 1'b0, 1'b1, 32'h3c01_0001);
      tick();
      checkOutput("t4_d_pc", d_pc, 32'hbfc0_0100);
      checkOutput("t4_d_instr", d_instr, 32'h3c01_0001);

      // 5: misaligned fetch PC raises adel without touching the bus
      applyStimulus(1'b1, 32'hbfc0_0002, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
      checkOutput("t5_ireq_valid", {31'b0, bus.ireq.valid}, 32'd0);
      checkOutput("t5_fstall", {31'b0, f_stall}, 32'd0);
      tick();
      checkOutput("t5_d_valid", {31'b0, d_valid}, 32'd1);
      checkOutput("t5_d_adel", {31'b0, d_adel}, 32'd1);
      checkOutput("t5_d_pc", d_pc, 32'hbfc0_0002);
      checkOutput("t5_d_instr", d_instr, 32'h0);
      checkOutput("t5_state_idle", 32'(dut.state), 32'(IDLE));

      // 6: reset in WAIT with a pending kill
      applyStimulus(1'b1, 32'hbfc0_0104, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
      tick();
      applyStimulus(1'b1, 32'hbfc0_0200, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
      tick();
      checkOutput("t6_kill_before", {31'b0, dut.kill}, 32'd1);
      reset = 1'b1;
      applyStimulus(1'b0, 32'hbfc0_0200, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
      tick();
      checkOutput("t6_state", 32'(dut.state), 32'(IDLE));
      checkOutput("t6_kill", {31'b0, dut.kill}, 32'd0);
      checkOutput("t6_d_valid", {31'b0, d_valid}, 32'd0);
      checkOutput("t6_ireq_valid", {31'b0, bus.ireq.valid}, 32'd0);
      reset = 1'b0;
      applyStimulus(1'b1, 32'hbfc0_0000, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
      checkOutput("t6_restart_valid", {31'b0, bus.ireq.valid}, 32'd1);
      checkOutput("t6_restart_addr", bus.ireq.addr, 32'hbfc0_0000);
      tick();

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
